reg_file: RTL and testbench
===========================

# reg_file

Parametrised register file for the multicycle datapath: 2^ADDR_WIDTH general-purpose registers of DATA_WIDTH bits, one write port, and two registered read ports. Read data is captured into internal A/B output registers on a clock edge, so the file drives the ALU operand latches directly. Write-to-read bypass, a hardwired zero register, and a synchronous bulk clear are configurable or provided.

## Interface
Parameters:
- DATA_WIDTH, 16: width of each register and of all data ports.
- ADDR_WIDTH, 3: address width; DEPTH = 2^ADDR_WIDTH registers.
- ZERO_REG, 1:
  - 1: register 0 always reads 0 and ignores writes.
  - 0: register 0 is ordinary.
- BYPASS, 1:
  - 1: a read capturing an address written in the same cycle returns the new write data.
  - 0: it returns the old contents.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of every register and both read outputs.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en_a  in  1  capture enable, port A.
- rd_addr_a  in  ADDR_WIDTH  read address, port A.
- rd_data_a  out  DATA_WIDTH  registered read data, port A.
- rd_en_b  in  1  capture enable, port B.
- rd_addr_b  in  ADDR_WIDTH  read address, port B.
- rd_data_b  out  DATA_WIDTH  registered read data, port B.

## Operation
- **Reset:** while reset=1, every register and both rd_data outputs are 0, independent of clk. After reset deasserts, the next rising edge operates normally.
- **Write:** on an edge with wr_en=1 and reset=0, clear=0, register[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- **Read, per port p:** on an edge with rd_en_p=1, rd_data_p <= value of register[rd_addr_p].
  - With rd_en_p=0, rd_data_p holds its previous value.
- **Read value selection, in priority order:**
  1. ZERO_REG=1 and rd_addr_p=0: 0.
  2. BYPASS=1, wr_en=1, wr_addr=rd_addr_p: wr_data.
  3. Otherwise: current stored contents.
- Both ports may read the same address in the same cycle and get identical data.
- **Clear:** on an edge with clear=1, all registers <= 0 and both rd_data <= 0.
  - Clear takes precedence over any write and any read capture in that cycle.
- A write whose wr_addr is out of range cannot occur: the address is exactly ADDR_WIDTH bits. No wrap logic is required.
- No combinational path from any input to rd_data_a or rd_data_b.

## Timing
- **Write latency:** data written at edge N is visible in storage after edge N.
  - BYPASS=0: a read captured at edge N+1 returns it.
  - BYPASS=1: a read captured at edge N already returns it.
- **Read latency:** 1 cycle. Address and enable are sampled at edge N; rd_data is valid after edge N and stable until the next enabled capture.
- **Reset mid-operation:** assertion zeroes all state immediately, not at a clock edge. An in-flight write or capture in that cycle is lost.
- **Simultaneous events:**
  - clear beats wr_en and rd_en.
  - reset beats everything.
  - A write and a read of the same register at the same edge follow the BYPASS rule above.
- No handshake; the controller is responsible for sequencing enables.

## Test plan
- **Reset:** write 0xBEEF to r3, then pulse reset between edges.
  - rd_data_a/b go to 0 immediately.
  - A subsequent read of r3 with rd_en_a=1 returns 0x0000.
- **Write/read and hold:** write 0x1234 to r5, 0xABCD to r6. Next edge, read A=r5, B=r6.
  - rd_data_a=0x1234 and rd_data_b=0xABCD one cycle later.
  - Drop rd_en_a/b and change the addresses: outputs hold.
- **Zero register (ZERO_REG=1):** write 0xFFFF to r0, then read r0 on both ports.
  - Both return 0x0000.
  - Repeat with ZERO_REG=0: both return 0xFFFF.
- **Bypass:** with r2=0x0001, at one edge write 0x00AA to r2 and capture A=r2.
  - BYPASS=1: rd_data_a=0x00AA.
  - BYPASS=0: rd_data_a=0x0001, and the next capture returns 0x00AA.
- **Clear precedence:** fill r1..r7 with nonzero values, then at one edge assert clear together with wr_en (r4←0x5555) and rd_en_a.
  - rd_data_a=0.
  - A full sweep of r0..r7 afterward reads all 0x0000.
- **Parameter sweep:** rerun the write/read scenario at DATA_WIDTH=8 and 32, ADDR_WIDTH=2 and 5.
  - Writing the value (address + 1) to every register, then reading each back, returns the same value with no aliasing.

Source files
------------

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   General-purpose register file for the multicycle datapath.
//   2^ADDR_WIDTH registers of DATA_WIDTH bits, one write port and two
//   registered read ports (A/B) that feed the ALU operand latches directly.
//
// Parameters
//   DATA_WIDTH : register / data port width
//   ADDR_WIDTH : address width, DEPTH = 2^ADDR_WIDTH
//   ZERO_REG   : 1 = register 0 reads as zero and ignores writes
//   BYPASS     : 1 = a capture of the address being written this cycle
//                    returns the new write data
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset of storage and read outputs
//   clear      : synchronous clear of storage and read outputs (beats write
//                and capture)
//   wr_en      : write strobe
//   wr_addr    : write address
//   wr_data    : write data
//   rd_en_a/b  : capture enable per read port
//   rd_addr_a/b: read address per read port
//   rd_data_a/b: registered read data per read port
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] sel_a_p0;
    logic [DATA_WIDTH-1:0] sel_b_p0;
    logic [DATA_WIDTH-1:0] rd_a_p1;
    logic [DATA_WIDTH-1:0] rd_b_p1;

    // Read value selection: hardwired zero first, then write bypass, then
    // the stored contents.
    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic [ADDR_WIDTH-1:0] ra,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH-1:0] v;
        v = stored;
        if ((ZERO_REG != 0) && (ra == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && we && (wa == ra)) begin
            v = wd;
        end
        return v;
    endfunction

    // Writes to the hardwired zero register are dropped here so r0 storage
    // never changes.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // ---- stage p0: operand selection from storage / write bus ----
    assign sel_a_p0 = read_sel(rd_addr_a, regs[rd_addr_a], wr_en, wr_addr, wr_data);
    assign sel_b_p0 = read_sel(rd_addr_b, regs[rd_addr_b], wr_en, wr_addr, wr_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ---- stage p1: registered read outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_p1 <= '0;
            rd_b_p1 <= '0;
        end else if (clear) begin
            rd_a_p1 <= '0;
            rd_b_p1 <= '0;
        end else begin
            if (rd_en_a) begin
                rd_a_p1 <= sel_a_p0;
            end
            if (rd_en_b) begin
                rd_b_p1 <= sel_b_p0;
            end
        end
    end

    assign rd_data_a = rd_a_p1;
    assign rd_data_b = rd_b_p1;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd_en_a;
    logic        rd_en_b;
    logic [4:0]  ra;
    logic [4:0]  rb;

    logic [15:0] a0, b0, a1, b1;
    logic [7:0]  a2, b2;
    logic [31:0] a3, b3;

    int total;
    int passed;

    // u0: default (zero reg, bypass)
    reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wa[2:0]), .wr_data(wd[15:0]),
        .rd_en_a(rd_en_a), .rd_addr_a(ra[2:0]), .rd_data_a(a0),
        .rd_en_b(rd_en_b), .rd_addr_b(rb[2:0]), .rd_data_b(b0)
    );

    // u1: ordinary r0, no bypass
    reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wa[2:0]), .wr_data(wd[15:0]),
        .rd_en_a(rd_en_a), .rd_addr_a(ra[2:0]), .rd_data_a(a1),
        .rd_en_b(rd_en_b), .rd_addr_b(rb[2:0]), .rd_data_b(b1)
    );

    // u2: narrow data, small address space
    reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(1), .BYPASS(0)) u2 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wa[1:0]), .wr_data(wd[7:0]),
        .rd_en_a(rd_en_a), .rd_addr_a(ra[1:0]), .rd_data_a(a2),
        .rd_en_b(rd_en_b), .rd_addr_b(rb[1:0]), .rd_data_b(b2)
    );

    // u3: wide data, large address space
    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(1)) u3 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
        .rd_en_a(rd_en_a), .rd_addr_a(ra), .rd_data_a(a3),
        .rd_en_b(rd_en_b), .rd_addr_b(rb), .rd_data_b(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1;
        wa    = 5'(a);
        wd    = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        rd_en_a = 1'b1;
        rd_en_b = 1'b1;
        ra      = 5'(a);
        rb      = 5'(b);
        step();
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        reset   = 1'b1;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wa      = '0;
        wd      = '0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        ra      = '0;
        rb      = '0;

        #12;
        chk("rst_a0", a0, 0);
        chk("rst_b0", b0, 0);
        chk("rst_a1", a1, 0);
        chk("rst_a3", a3, 0);
        reset = 1'b0;

        // Reset mid-operation
        wr(3, 32'h0000BEEF);
        rd(3, 3);
        chk("r3_a_before_rst", a0, 32'hBEEF);
        chk("r3_b_before_rst", b0, 32'hBEEF);
        reset = 1'b1;
        #2;
        chk("async_rst_a", a0, 0);
        chk("async_rst_b", b0, 0);
        reset = 1'b0;
        rd(3, 3);
        chk("r3_after_rst", a0, 0);

        // Write / read / hold
        wr(5, 32'h00001234);
        wr(6, 32'h0000ABCD);
        rd(5, 6);
        chk("rd_r5_u0", a0, 32'h1234);
        chk("rd_r6_u0", b0, 32'hABCD);
        chk("rd_r5_u1", a1, 32'h1234);
        chk("rd_r6_u1", b1, 32'hABCD);
        ra = 5'd1;
        rb = 5'd2;
        step();
        chk("hold_a", a0, 32'h1234);
        chk("hold_b", b0, 32'hABCD);

        // Zero register
        wr(0, 32'h0000FFFF);
        rd(0, 0);
        chk("zero_a_u0", a0, 0);
        chk("zero_b_u0", b0, 0);
        chk("r0_a_u1", a1, 32'hFFFF);
        chk("r0_b_u1", b1, 32'hFFFF);

        // Bypass
        wr(2, 32'h00000001);
        wr_en   = 1'b1;
        wa      = 5'd2;
        wd      = 32'h000000AA;
        rd_en_a = 1'b1;
        ra      = 5'd2;
        step();
        wr_en   = 1'b0;
        chk("bypass_u0", a0, 32'h00AA);
        chk("nobypass_u1", a1, 32'h0001);
        step();
        rd_en_a = 1'b0;
        chk("nobypass_next_u1", a1, 32'h00AA);

        // Clear precedence
        for (int i = 1; i < 8; i++) wr(i, 32'h1111 * i);
        rd(7, 4);
        chk("fill_r7", a0, 32'h7777);
        chk("fill_r4", b1, 32'h4444);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wa      = 5'd4;
        wd      = 32'h00005555;
        rd_en_a = 1'b1;
        ra      = 5'd1;
        step();
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_en_a = 1'b0;
        chk("clr_a_u0", a0, 0);
        chk("clr_b_u0", b0, 0);
        chk("clr_a_u1", a1, 0);
        chk("clr_b_u1", b1, 0);
        for (int i = 0; i < 8; i++) begin
            rd(i, 7 - i);
            chk($sformatf("sweep_a_u0_r%0d", i), a0, 0);
            chk($sformatf("sweep_b_u0_r%0d", 7 - i), b0, 0);
            chk($sformatf("sweep_a_u1_r%0d", i), a1, 0);
        end

        // Parameter sweep: 32-bit x 32 entries
        for (int i = 0; i < 32; i++) wr(i, 32'(i + 1));
        for (int i = 0; i < 32; i++) begin
            rd(i, 31 - i);
            chk($sformatf("w32_a_r%0d", i), a3, 32'(i + 1));
            chk($sformatf("w32_b_r%0d", 31 - i), b3, 32'(32 - i));
        end

        // Parameter sweep: 8-bit x 4 entries (r0 hardwired zero)
        for (int i = 0; i < 4; i++) wr(i, 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            rd(i, 3 - i);
            chk($sformatf("w8_a_r%0d", i), a2, (i == 0) ? 32'd0 : 32'(i + 1));
            chk($sformatf("w8_b_r%0d", 3 - i), b2, (i == 3) ? 32'd0 : 32'(4 - i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
